// File: rtl/memory_pkg.sv
// memory_pkg: shared state type, default geometry and even-parity helper for memory_bank.
package memory_pkg;
  typedef enum logic {ST_INIT, ST_IDLE} state_e;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 10;
  localparam int PAR_MAX_W = 1024;
  function automatic logic parity(input logic [PAR_MAX_W-1:0] w);
    return ^w;
  endfunction
endpackage

// File: rtl/memory_init_seq.sv
// memory_init_seq: walks every word address once after reset, then parks in IDLE.
module memory_init_seq
  import memory_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              CLK,
  input  logic              RST,
  output logic              init_we_o,
  output logic [ADDR_W-1:0] init_addr_o,
  output logic              init_busy_o
);
  state_e state_q;
  logic [ADDR_W-1:0] cnt_q;
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= ST_INIT;
      cnt_q       <= '0;
      init_busy_o <= 1'b1;
    end else if (state_q == ST_INIT) begin
      cnt_q <= cnt_q + ADDR_W'(1);
      if (&cnt_q) begin
        state_q     <= ST_IDLE;
        init_busy_o <= 1'b0;
      end
    end
  end
  assign init_we_o   = state_q == ST_INIT;
  assign init_addr_o = cnt_q;
endmodule

// File: rtl/memory_bank.sv
// memory_bank: single-port bit-write RAM with sequential init engine and read-valid strobe.
// Optional stored even parity with error injection when MEMORY_BANK_PARITY_EN is defined.
module memory_bank
  import memory_pkg::*;
#(
  parameter int                DATA_W   = DEF_DATA_W,
  parameter int                ADDR_W   = DEF_ADDR_W,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              REQ,
  input  logic              WE,
  input  logic [DATA_W-1:0] BWEN,
  input  logic [ADDR_W-1:0] A,
  input  logic [DATA_W-1:0] D,
  output logic              READY,
  output logic [DATA_W-1:0] Q,
  output logic              QVALID,
  output logic              INIT_BUSY
`ifdef MEMORY_BANK_PARITY_EN
  ,
  input  logic              PINJ,
  output logic              PERR
`endif
);
  localparam int DEPTH = 2 ** ADDR_W;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              init_we;
  logic [ADDR_W-1:0] init_addr, waddr;
  logic              acc, wr, rd;
  logic [DATA_W-1:0] word, wdata_d;
  memory_init_seq #(.ADDR_W(ADDR_W)) u_init (
    .CLK(CLK),
    .RST(RST),
    .init_we_o(init_we),
    .init_addr_o(init_addr),
    .init_busy_o(INIT_BUSY)
  );
  assign READY = ~INIT_BUSY;
  // RST in the same cycle as a request drops the access entirely
  assign acc     = REQ & READY & ~RST;
  assign wr      = acc & WE;
  assign rd      = acc & ~WE;
  assign word    = mem_q[A];
  assign wdata_d = init_we ? INIT_VAL : (word & ~BWEN) | (D & BWEN);
  assign waddr   = init_we ? init_addr : A;
`ifdef MEMORY_BANK_PARITY_EN
  logic par_q [DEPTH];
  logic par_d;
  assign par_d = parity(PAR_MAX_W'(wdata_d)) ^ (wr & PINJ);
  always_ff @(posedge CLK) begin
    if (!RST && (init_we || wr)) begin
      mem_q[waddr] <= wdata_d;
      par_q[waddr] <= par_d;
    end
  end
  always_ff @(posedge CLK) begin
    if (RST) PERR <= 1'b0;
    else PERR <= rd & (par_q[A] != parity(PAR_MAX_W'(word)));
  end
`else
  always_ff @(posedge CLK) begin
    if (!RST && (init_we || wr)) mem_q[waddr] <= wdata_d;
  end
`endif
  always_ff @(posedge CLK) begin
    if (RST) begin
      Q      <= '0;
      QVALID <= 1'b0;
    end else begin
      QVALID <= rd;
      if (rd) Q <= word;
    end
  end
endmodule

// File: doc/memory_bank.md
Name: memory_bank

Overview:
Parametrised single-port synchronous memory, successor to the fixed 1024x32 bit-write memory.
- Width and depth are generic.
- The single-cycle global clear is replaced by a sequential init engine that zeroes one word per cycle.
- Adds a request/ready handshake and a read-valid strobe.
- Sits between the core load/store unit or fetch unit and local storage, as instruction or data RAM.

Parameters:
DATA_W, 32, word width in bits
ADDR_W, 10, address width; DEPTH = 2**ADDR_W words
INIT_VAL, 0, word value written by the init engine

Ports:
CLK  in  1  clock, all logic on rising edge
RST  in  1  synchronous, active-high reset
REQ  in  1  access request, active-high
WE  in  1  1 = write, 0 = read (qualified by REQ)
BWEN  in  DATA_W  per-bit write enable; 1 = bit updated
A  in  ADDR_W  word address
D  in  DATA_W  write data
READY  out  1  1 = request accepted this cycle
Q  out  DATA_W  read data, registered
QVALID  out  1  Q updated with read data this cycle
INIT_BUSY  out  1  init engine running

Behaviour:
- Clocking and reset: one clock (CLK). Reset RST is synchronous and active-high.
- Reset values: READY=0, Q=0, QVALID=0, INIT_BUSY=1, init address counter=0, state=INIT.
- State INIT:
  - Writes INIT_VAL to word[cnt] each cycle and increments cnt.
  - At cnt == DEPTH-1, writes the last word and moves to IDLE next cycle.
  - Takes exactly DEPTH cycles after RST deasserts.
  - READY=0 throughout; REQ is ignored, with no queuing.
- State IDLE:
  - READY=1. Accept = REQ & READY.
  - Write accept: word[A][i] <= BWEN[i] ? D[i] : word[A][i] for every bit i. BWEN all-zero is a legal no-op that still counts as accepted. Q and QVALID are unchanged.
  - Read accept: Q <= word[A] at the same edge; QVALID=1 for exactly that following cycle. Latency is 1 cycle.
  - Back-to-back reads each cycle give a continuous QVALID.
- Q holding: Q keeps its last read value when QVALID=0. Writes never alter Q, even for the same address.
- Read-after-write: a write to X in cycle n followed by a read of X in cycle n+1 returns the merged new data. No forwarding is needed because the write has committed.
- RST during INIT: counter restarts at 0 and the full DEPTH-cycle init repeats.
- RST during IDLE with REQ high: the access is dropped. Q=0, QVALID=0, re-init follows.
- Address: A is full width; all codes are valid, so there is no out-of-range case.
- The counter is ADDR_W+1 bits wide or compares against DEPTH-1, so it never wraps silently.

Optional Feature:
MEMORY_BANK_PARITY_EN
- Defined:
  - Each word stores an extra even-parity bit computed over the merged post-write word. The init engine writes parity(INIT_VAL).
  - Extra output PERR (1 bit): asserted together with QVALID when the stored parity mismatches the read word, otherwise 0. Reset value 0.
  - Extra input PINJ (1 bit): on an accepted write, inverts the stored parity bit to allow error injection.
- Undefined: no parity storage, and the PERR/PINJ ports are absent.

Decomposition:
- Package memory_pkg:
  - state enum (INIT, IDLE)
  - default DATA_W/ADDR_W constants
  - parity function used by the core and the bench
- One sub-module, memory_init_seq:
  - holds the address counter and the INIT/IDLE state
  - outputs init_we, init_addr and INIT_BUSY
  - memory_bank muxes its write port between init_seq and the user port.

Test Plan:
1. RST high 2 cycles, then low -> INIT_BUSY=1 for exactly 1024 cycles, READY rises on cycle 1024; reading words 0, 511 and 1023 each returns 0x00000000 with QVALID one cycle later.
2. Write A=5, D=0xDEADBEEF, BWEN=0xFFFFFFFF; next cycle write A=5, D=0x00000000, BWEN=0x0000FFFF; next cycle read A=5 -> Q=0xDEAD0000, QVALID=1 for one cycle.
3. Reads of A=1,2,3 on consecutive cycles after writing 0x11,0x22,0x33 -> Q=0x11,0x22,0x33 on consecutive cycles, QVALID high for 3 cycles; Q holds 0x33 afterwards.
4. REQ=1, WE=1, A=7, D=0xFFFFFFFF during INIT (cycle 100) -> ignored; after init, reading A=7 returns 0.
5. RST pulsed at init cycle 500 -> INIT_BUSY stays 1 for a further 1024 cycles; RST during a read -> QVALID=0 and Q=0 next cycle.
6. (MEMORY_BANK_PARITY_EN) Write A=9, D=0x1, PINJ=1, then read A=9 -> Q=0x00000001, PERR=1; rewrite with PINJ=0 and read -> PERR=0.
